// File: rtl/lift_pkg.sv
// Shared types and helpers for the lift call register: direction decode,
// one-hot checks and population count over a MAX_FLOORS-wide vector.
package lift_pkg;

   localparam int MAX_FLOORS = 32;
   localparam int IDX_W      = 5;
   localparam int POP_W      = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DN   = 2'd2
   } dir_t;

   function automatic logic is_onehot(input logic [MAX_FLOORS-1:0] vec);
      return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
   endfunction

   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_FLOORS-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = 5'd0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         if (vec[i]) begin
            idx = idx | IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   function automatic logic [POP_W-1:0] popcount(input logic [MAX_FLOORS-1:0] vec);
      logic [POP_W-1:0] cnt;
      cnt = 6'd0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         cnt = cnt + POP_W'(vec[i]);
      end
      return cnt;
   endfunction

   // Both direction bits high is treated as idle.
   function automatic dir_t decode_dir(input logic dir_up, input logic dir_dn);
      dir_t d;
      case ({dir_up, dir_dn})
         2'b10:   d = UP;
         2'b01:   d = DN;
         default: d = IDLE;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/lift_call_reg_n_if.sv
// Bus between the lift controller and the call register. The car_cancel
// signal exists only when LIFT_CAR_CANCEL_EN is defined.
interface lift_call_reg_n_if #(
   parameter int N_FLOORS = 6
);
   localparam int CNT_W = $clog2(3*N_FLOORS+1);

`ifdef LIFT_CAR_CANCEL_EN
   logic [N_FLOORS-1:0] car_cancel;
`endif
   logic [N_FLOORS-1:0] car_call_sig;
   logic [N_FLOORS-1:0] hall_up_sig;
   logic [N_FLOORS-1:0] hall_dn_sig;
   logic [N_FLOORS-1:0] sensor;
   logic                open_door;
   logic                dir_up;
   logic                dir_dn;
   logic [N_FLOORS-1:0] car_call;
   logic [N_FLOORS-1:0] hall_up;
   logic [N_FLOORS-1:0] hall_dn;
   logic                call_above;
   logic                call_below;
   logic                call_here;
   logic [CNT_W-1:0]    pending_cnt;
   logic                served;
   logic                sensor_err;

   modport master (
`ifdef LIFT_CAR_CANCEL_EN
      output car_cancel,
`endif
      output car_call_sig, hall_up_sig, hall_dn_sig, sensor, open_door, dir_up, dir_dn,
      input  car_call, hall_up, hall_dn, call_above, call_below, call_here,
      input  pending_cnt, served, sensor_err
   );

   modport slave (
`ifdef LIFT_CAR_CANCEL_EN
      input  car_cancel,
`endif
      input  car_call_sig, hall_up_sig, hall_dn_sig, sensor, open_door, dir_up, dir_dn,
      output car_call, hall_up, hall_dn, call_above, call_below, call_here,
      output pending_cnt, served, sensor_err
   );

endinterface

// File: rtl/lift_call_summary.sv
// Combinational request summary: where latched calls sit relative to the
// current floor, and how many calls are pending in total.
module lift_call_summary
   import lift_pkg::*;
#(
   parameter int N_FLOORS = 6,
   parameter int CNT_W    = $clog2(3*N_FLOORS+1)
) (
   input  logic [N_FLOORS-1:0] car_call,
   input  logic [N_FLOORS-1:0] hall_up,
   input  logic [N_FLOORS-1:0] hall_dn,
   input  logic [IDX_W-1:0]    cur_floor,
   output logic                above,
   output logic                below,
   output logic                here,
   output logic [CNT_W-1:0]    cnt
);

   logic [N_FLOORS-1:0]   any_s;
   logic [N_FLOORS-1:0]   here_mask_s;
   logic [N_FLOORS-1:0]   below_mask_s;
   logic [N_FLOORS-1:0]   above_mask_s;
   logic [MAX_FLOORS-1:0] car_ext_s;
   logic [MAX_FLOORS-1:0] up_ext_s;
   logic [MAX_FLOORS-1:0] dn_ext_s;

   // Masks derive from a single shifted one: floors below are every lower bit.
   always_comb begin
      any_s        = car_call | hall_up | hall_dn;
      here_mask_s  = {{(N_FLOORS-1){1'b0}}, 1'b1} << cur_floor;
      below_mask_s = here_mask_s - {{(N_FLOORS-1){1'b0}}, 1'b1};
      above_mask_s = ~(below_mask_s | here_mask_s);
      above        = |(any_s & above_mask_s);
      below        = |(any_s & below_mask_s);
      here         = |(any_s & here_mask_s);

      car_ext_s    = {MAX_FLOORS{1'b0}};
      up_ext_s     = {MAX_FLOORS{1'b0}};
      dn_ext_s     = {MAX_FLOORS{1'b0}};
      car_ext_s[N_FLOORS-1:0] = car_call;
      up_ext_s[N_FLOORS-1:0]  = hall_up;
      dn_ext_s[N_FLOORS-1:0]  = hall_dn;
      cnt = CNT_W'(popcount(car_ext_s)) + CNT_W'(popcount(up_ext_s))
          + CNT_W'(popcount(dn_ext_s));
   end

endmodule

// File: rtl/lift_call_reg_n.sv
// N-floor call register: latches car/hall calls, clears them on door-open by
// direction, and publishes registered summaries. LIFT_CAR_CANCEL_EN adds car_cancel.
module lift_call_reg_n
   import lift_pkg::*;
#(
   parameter int N_FLOORS = 6,
   parameter int CNT_W    = $clog2(3*N_FLOORS+1)
) (
   input  logic              clk,
   input  logic              rst,
   lift_call_reg_n_if.slave  bus
);

   localparam logic [N_FLOORS-1:0] UP_VALID = {1'b0, {(N_FLOORS-1){1'b1}}};
   localparam logic [N_FLOORS-1:0] DN_VALID = {{(N_FLOORS-1){1'b1}}, 1'b0};

   logic [N_FLOORS-1:0]   car_call_q, car_call_d;
   logic [N_FLOORS-1:0]   hall_up_q, hall_up_d;
   logic [N_FLOORS-1:0]   hall_dn_q, hall_dn_d;
   logic [IDX_W-1:0]      cur_floor_q, cur_floor_d;
   logic                  served_q, served_d;
   logic                  sensor_err_q, sensor_err_d;
   logic                  call_above_q, call_below_q, call_here_q;
   logic [CNT_W-1:0]      pending_cnt_q;

   logic [MAX_FLOORS-1:0] sensor_ext_s;
   logic                  onehot_s;
   logic                  multi_s;
   logic [IDX_W-1:0]      idx_s;
   dir_t                  dir_s;
   logic [N_FLOORS-1:0]   clr_mask_s;
   logic [N_FLOORS-1:0]   car_clr_s, up_clr_s, dn_clr_s;
   logic [N_FLOORS-1:0]   cancel_s;
   logic                  above_s, below_s, here_s;
   logic [CNT_W-1:0]      cnt_s;

   // Next-state: latch presses, then apply service clears and cancels on top.
   always_comb begin
      sensor_ext_s = {MAX_FLOORS{1'b0}};
      sensor_ext_s[N_FLOORS-1:0] = bus.sensor;
      onehot_s = is_onehot(sensor_ext_s);
      multi_s  = (bus.sensor != {N_FLOORS{1'b0}}) && !onehot_s;
      idx_s    = onehot_to_idx(sensor_ext_s);
      dir_s    = decode_dir(bus.dir_up, bus.dir_dn);

      if (onehot_s) begin
         cur_floor_d = idx_s;
      end else begin
         cur_floor_d = cur_floor_q;
      end

      if (bus.open_door && onehot_s) begin
         clr_mask_s = bus.sensor;
      end else begin
         clr_mask_s = {N_FLOORS{1'b0}};
      end

      car_clr_s = clr_mask_s;
      case (dir_s)
         UP: begin
            up_clr_s = clr_mask_s;
            dn_clr_s = {N_FLOORS{1'b0}};
         end
         DN: begin
            up_clr_s = {N_FLOORS{1'b0}};
            dn_clr_s = clr_mask_s;
         end
         default: begin
            up_clr_s = clr_mask_s;
            dn_clr_s = clr_mask_s;
         end
      endcase

`ifdef LIFT_CAR_CANCEL_EN
      cancel_s = bus.car_cancel;
`else
      cancel_s = {N_FLOORS{1'b0}};
`endif

      car_call_d = (car_call_q | bus.car_call_sig) & ~car_clr_s & ~cancel_s;
      hall_up_d  = (hall_up_q | bus.hall_up_sig) & ~up_clr_s & UP_VALID;
      hall_dn_d  = (hall_dn_q | bus.hall_dn_sig) & ~dn_clr_s & DN_VALID;

      // Only calls that were actually latched count as served.
      served_d = (|(car_call_q & car_clr_s)) | (|(hall_up_q & up_clr_s))
               | (|(hall_dn_q & dn_clr_s));
      sensor_err_d = sensor_err_q | multi_s;
   end

   lift_call_summary #(
      .N_FLOORS (N_FLOORS),
      .CNT_W    (CNT_W)
   ) u_summary (
      .car_call  (car_call_q),
      .hall_up   (hall_up_q),
      .hall_dn   (hall_dn_q),
      .cur_floor (cur_floor_q),
      .above     (above_s),
      .below     (below_s),
      .here      (here_s),
      .cnt       (cnt_s)
   );

   // State and output registers; reset wins over every same-cycle event.
   always_ff @(posedge clk) begin
      if (rst) begin
         car_call_q    <= {N_FLOORS{1'b0}};
         hall_up_q     <= {N_FLOORS{1'b0}};
         hall_dn_q     <= {N_FLOORS{1'b0}};
         cur_floor_q   <= {IDX_W{1'b0}};
         served_q      <= 1'b0;
         sensor_err_q  <= 1'b0;
         call_above_q  <= 1'b0;
         call_below_q  <= 1'b0;
         call_here_q   <= 1'b0;
         pending_cnt_q <= {CNT_W{1'b0}};
      end else begin
         car_call_q    <= car_call_d;
         hall_up_q     <= hall_up_d;
         hall_dn_q     <= hall_dn_d;
         cur_floor_q   <= cur_floor_d;
         served_q      <= served_d;
         sensor_err_q  <= sensor_err_d;
         call_above_q  <= above_s;
         call_below_q  <= below_s;
         call_here_q   <= here_s;
         pending_cnt_q <= cnt_s;
      end
   end

   assign bus.car_call    = car_call_q;
   assign bus.hall_up     = hall_up_q;
   assign bus.hall_dn     = hall_dn_q;
   assign bus.call_above  = call_above_q;
   assign bus.call_below  = call_below_q;
   assign bus.call_here   = call_here_q;
   assign bus.pending_cnt = pending_cnt_q;
   assign bus.served      = served_q;
   assign bus.sensor_err  = sensor_err_q;

endmodule

// File: tb/tb_lift_call_reg_n.sv
// Directed and random stimulus for lift_call_reg_n against a per-floor
// behavioural model of the call register.
module tb_lift_call_reg_n;

   localparam int N = 6;

   logic clk;
   logic rst;

   lift_call_reg_n_if #(.N_FLOORS(N)) bus ();

   lift_call_reg_n #(.N_FLOORS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   bit [N-1:0] m_car, m_up, m_dn;
   int         m_floor;
   bit         m_err;
   bit         e_above, e_below, e_here, e_served;
   int         e_cnt;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_inputs();
`ifdef LIFT_CAR_CANCEL_EN
      bus.car_cancel = '0;
`endif
      bus.car_call_sig = '0;
      bus.hall_up_sig  = '0;
      bus.hall_dn_sig  = '0;
      bus.sensor       = '0;
      bus.open_door    = 1'b0;
      bus.dir_up       = 1'b0;
      bus.dir_dn       = 1'b0;
   endtask

   // Reference model: evaluated once per rising edge from the current inputs.
   task automatic model_edge();
      int ones, f;
      bit [N-1:0] nc, nu, nd;
      bit srv, anyc;
      if (rst) begin
         m_car = '0; m_up = '0; m_dn = '0; m_floor = 0; m_err = 0;
         e_above = 0; e_below = 0; e_here = 0; e_served = 0; e_cnt = 0;
         return;
      end
      ones = 0; f = 0;
      for (int i = 0; i < N; i++) begin
         if (bus.sensor[i]) begin
            ones++;
            f = i;
         end
      end
      e_above = 0; e_below = 0; e_here = 0; e_cnt = 0;
      for (int i = 0; i < N; i++) begin
         anyc  = m_car[i] | m_up[i] | m_dn[i];
         e_cnt += int'(m_car[i]) + int'(m_up[i]) + int'(m_dn[i]);
         if (anyc && i > m_floor) e_above = 1;
         if (anyc && i < m_floor) e_below = 1;
         if (anyc && i == m_floor) e_here = 1;
      end
      srv = 0;
      for (int i = 0; i < N; i++) begin
         nc[i] = m_car[i] | bus.car_call_sig[i];
         nu[i] = (i != N-1) && (m_up[i] || bus.hall_up_sig[i]);
         nd[i] = (i != 0) && (m_dn[i] || bus.hall_dn_sig[i]);
`ifdef LIFT_CAR_CANCEL_EN
         if (bus.car_cancel[i]) nc[i] = 0;
`endif
         if (bus.open_door && ones == 1 && i == f) begin
            if (m_car[i]) srv = 1;
            nc[i] = 0;
            if (!(bus.dir_dn && !bus.dir_up)) begin
               if (m_up[i]) srv = 1;
               nu[i] = 0;
            end
            if (!(bus.dir_up && !bus.dir_dn)) begin
               if (m_dn[i]) srv = 1;
               nd[i] = 0;
            end
         end
      end
      m_car = nc; m_up = nu; m_dn = nd;
      e_served = srv;
      if (ones == 1) m_floor = f;
      if (ones > 1) m_err = 1;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("car_call",    bus.car_call,    m_car);
      chk("hall_up",     bus.hall_up,     m_up);
      chk("hall_dn",     bus.hall_dn,     m_dn);
      chk("call_above",  bus.call_above,  e_above);
      chk("call_below",  bus.call_below,  e_below);
      chk("call_here",   bus.call_here,   e_here);
      chk("pending_cnt", bus.pending_cnt, e_cnt);
      chk("served",      bus.served,      e_served);
      chk("sensor_err",  bus.sensor_err,  m_err);
   endtask

   task automatic reset_step();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int a;
      // Reset with every input held high.
      rst = 1'b1;
`ifdef LIFT_CAR_CANCEL_EN
      bus.car_cancel = '1;
`endif
      bus.car_call_sig = '1; bus.hall_up_sig = '1; bus.hall_dn_sig = '1;
      bus.sensor = '1; bus.open_door = 1'b1; bus.dir_up = 1'b1; bus.dir_dn = 1'b1;
      step();
      step();
      chk("rst_pending", bus.pending_cnt, 0);
      chk("rst_err", bus.sensor_err, 0);
      chk("rst_car", bus.car_call, 0);
      rst = 1'b0;
      idle_inputs();

      // Hall up at floor 2 from floor 0.
      bus.hall_up_sig = 6'b000100; bus.sensor = 6'b000001;
      step();
      chk("d1_hall_up", bus.hall_up, 6'b000100);
      idle_inputs();
      step();
      chk("d1_above", bus.call_above, 1);
      chk("d1_pending", bus.pending_cnt, 1);

      // Service at floor 3 travelling up.
      reset_step();
      bus.car_call_sig = 6'b001000; bus.hall_up_sig = 6'b001000; bus.hall_dn_sig = 6'b001000;
      step();
      idle_inputs();
      step();
      chk("d2_pending_pre", bus.pending_cnt, 3);
      bus.sensor = 6'b001000; bus.open_door = 1'b1; bus.dir_up = 1'b1;
      step();
      chk("d2_car", bus.car_call, 0);
      chk("d2_up", bus.hall_up, 0);
      chk("d2_dn", bus.hall_dn, 6'b001000);
      chk("d2_served", bus.served, 1);
      idle_inputs();
      step();
      chk("d2_served_end", bus.served, 0);
      chk("d2_pending_post", bus.pending_cnt, 1);

      // Idle service at floor 3 with a same-cycle car press.
      reset_step();
      bus.car_call_sig = 6'b001000; bus.hall_up_sig = 6'b001000; bus.hall_dn_sig = 6'b001000;
      step();
      idle_inputs();
      bus.sensor = 6'b001000; bus.open_door = 1'b1; bus.car_call_sig = 6'b001000;
      step();
      chk("d3_car", bus.car_call, 0);
      chk("d3_up", bus.hall_up, 0);
      chk("d3_dn", bus.hall_dn, 0);

      // Multi-hot sensor with door open: no clear, sticky error, floor held at 3.
      idle_inputs();
      bus.car_call_sig = 6'b000010;
      step();
      idle_inputs();
      bus.sensor = 6'b010010; bus.open_door = 1'b1;
      step();
      chk("d4_car", bus.car_call, 6'b000010);
      chk("d4_err", bus.sensor_err, 1);
      idle_inputs();
      step();
      chk("d4_err_sticky", bus.sensor_err, 1);
      chk("d4_below", bus.call_below, 1);
      chk("d4_here", bus.call_here, 0);

      // Invalid hall bits at the terminal floors.
      reset_step();
      bus.hall_up_sig = 6'b100000; bus.hall_dn_sig = 6'b000001;
      step();
      idle_inputs();
      step();
      chk("d5_pending", bus.pending_cnt, 0);
      chk("d5_up", bus.hall_up, 0);
      chk("d5_dn", bus.hall_dn, 0);

`ifdef LIFT_CAR_CANCEL_EN
      bus.car_call_sig = 6'b000100;
      step();
      bus.car_cancel = 6'b000100;
      step();
      chk("cc_car", bus.car_call, 0);
      chk("cc_served", bus.served, 0);
      idle_inputs();
`endif

      // Random traffic with occasional resets and rare multi-hot sensor.
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst = ($urandom_range(0, 49) == 0);
         bus.car_call_sig = N'($urandom & $urandom & $urandom);
         bus.hall_up_sig  = N'($urandom & $urandom & $urandom);
         bus.hall_dn_sig  = N'($urandom & $urandom & $urandom);
`ifdef LIFT_CAR_CANCEL_EN
         bus.car_cancel   = N'($urandom & $urandom & $urandom);
`endif
         a = int'($urandom_range(0, 199));
         if (a < 60) begin
            bus.sensor = '0;
         end else if (a < 199) begin
            bus.sensor = N'(1) << $urandom_range(0, N-1);
         end else begin
            a = int'($urandom_range(0, N-2));
            bus.sensor = (N'(1) << a) | (N'(1) << (a + 1));
         end
         bus.open_door = ($urandom_range(0, 2) == 0);
         bus.dir_up    = 1'($urandom);
         bus.dir_dn    = 1'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
